ysyx_22041211_mem_responder: RTL and testbench

Memory-side responder for the core's data/instruction memory port. It accepts one read or write request at a time over a valid/ready request channel and holds a word-addressed storage array. It returns a right-aligned read word or write acknowledge, with an error flag, over a valid/ready response channel after a programmable latency. It replaces the zero-latency DPI memory path, so the core can be exercised against realistic multi-cycle memory.

---
 rtl/ysyx_22041211_mem_responder.sv | 81 ++++++++
 tb/tb_ysyx_22041211_mem_responder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_mem_responder.sv
// ysyx_22041211_mem_responder: word-addressed memory behind valid/ready request/response channels with programmable latency
module ysyx_22041211_mem_responder #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 'h80000000,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic [7:0]          req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_rdata,
  output logic                rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n, lat, size, be;
  logic [ADDR_LEN-1:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0] lane;
  logic [DATA_LEN-1:0] wdata_sh;
  logic err, accept;
  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];
  assign off = req_addr - BASE_ADDR;
  assign idx = off[DEPTH_LOG2+1:2];
  assign lane = off[1:0];
  assign size = req_wmask == 8'h01 ? 4'h1 : req_wmask == 8'h03 ? 4'h3 :
                (req_wmask == 8'h0f || req_wmask == 8'hff) ? 4'hf : 4'h0;
  assign be = size << lane;
  assign wdata_sh = req_wdata << {lane, 3'b000};
  assign err = off >= ADDR_LEN'(4 << DEPTH_LOG2) || size == 4'h0 ||
               (size == 4'h3 && lane[0]) || (size == 4'hf && lane != 2'd0);
  assign req_ready = rst && state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  assign lat = req_wen ? 4'(WR_LATENCY - 1) : 4'(RD_LATENCY - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = lat == 4'd0 ? RESP : WAIT;
        cnt_n = lat;
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        rsp_err <= err;
        rsp_rdata <= (err || req_wen) ? '0 : mem[idx] >> {lane, 3'b000};
      end
    end
  end
  // the array is deliberately outside reset so committed writes survive it
  always_ff @(posedge clk)
    if (accept && req_wen && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
endmodule

// File: tb/tb_ysyx_22041211_mem_responder.sv
// tb_ysyx_22041211_mem_responder: directed checks of the memory responder with default and alternate latencies
module tb_ysyx_22041211_mem_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0] req_wmask;
  logic b_rst, b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [7:0] b_req_wmask;
  int passed = 0, fails = 0, total = 0;
  ysyx_22041211_mem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  ysyx_22041211_mem_responder #(.RD_LATENCY(1), .WR_LATENCY(3)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [7:0] mask, output logic [31:0] rdata, output logic err, output int lat);
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
  endtask
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [7:0] mask, input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic e;
    int l;
    do_req(wen, addr, wdata, mask, rd, e, l);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask
  initial begin
    int l;
    rst = 0; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; rsp_ready = 0;
    b_rst = 0; b_req_valid = 0; b_req_wen = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wmask = 0; b_rsp_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    rst = 1; b_rst = 1;
    @(negedge clk);
    chk("rel_req_ready", {31'b0, req_ready}, 1);
    txn("wr_word", 1, 32'h80000010, 32'hDEADBEEF, 8'h0F, 0, 0, 1);
    txn("rd_word", 0, 32'h80000010, 0, 8'h0F, 32'hDEADBEEF, 0, 2);
    txn("wr_byte", 1, 32'h80000013, 32'h000000AA, 8'h01, 0, 0, 1);
    txn("rd_after_byte", 0, 32'h80000010, 0, 8'hFF, 32'hAAADBEEF, 0, 2);
    txn("rd_byte3", 0, 32'h80000013, 0, 8'h01, 32'h000000AA, 0, 2);
    txn("rd_half_odd", 0, 32'h80000011, 0, 8'h03, 0, 1, 2);
    txn("wr_word_mis", 1, 32'h80000012, 32'h11111111, 8'h0F, 0, 1, 1);
    txn("wr_bad_mask", 1, 32'h80000010, 32'h22222222, 8'h07, 0, 1, 1);
    txn("rd_unchanged", 0, 32'h80000010, 0, 8'h0F, 32'hAAADBEEF, 0, 2);
    txn("rd_below", 0, 32'h7FFFFFFC, 0, 8'h0F, 0, 1, 2);
    txn("rd_above", 0, 32'h80001000, 0, 8'h0F, 0, 1, 2);
    do_req(0, 32'h80000FFC, 0, 8'h0F, req_wdata, req_wen, l);
    chk("rd_last_err", {31'b0, req_wen}, 0);
    txn("wr_half", 1, 32'h80000012, 32'hFFFF1234, 8'h03, 0, 0, 1);
    txn("rd_half", 0, 32'h80000012, 0, 8'h03, 32'h00001234, 0, 2);
    txn("rd_after_half", 0, 32'h80000010, 0, 8'h0F, 32'h1234BEEF, 0, 2);
    txn("wr_zero", 1, 32'h80000020, 0, 8'h0F, 0, 0, 1);
    req_valid = 1; req_wen = 0; req_addr = 32'h80000010; req_wmask = 8'h0F; rsp_ready = 0;
    @(negedge clk);
    req_valid = 0;
    l = 1;
    while (!rsp_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    chk("bp_lat", l, 2);
    req_valid = 1; req_wen = 1; req_addr = 32'h80000020; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h1234BEEF);
      chk("bp_rsp_err", {31'b0, rsp_err}, 0);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
    end
    rsp_ready = 1;
    req_valid = 0;
    @(negedge clk);
    chk("bp_done_valid", {31'b0, rsp_valid}, 0);
    chk("bp_done_ready", {31'b0, req_ready}, 1);
    txn("bp_ignored", 0, 32'h80000020, 0, 8'h0F, 0, 0, 2);
    b_req_valid = 1; b_req_wen = 1; b_req_addr = 32'h80000044; b_req_wdata = 32'hCAFEF00D; b_req_wmask = 8'h0F;
    @(negedge clk);
    b_req_valid = 0;
    l = 1;
    while (!b_rsp_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    chk("b_wr_lat", l, 3);
    @(negedge clk);
    b_req_valid = 1; b_req_wen = 0;
    @(negedge clk);
    b_req_valid = 0;
    chk("b_rd_lat1_valid", {31'b0, b_rsp_valid}, 1);
    chk("b_rd_lat1_rdata", b_rsp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    b_req_valid = 1; b_req_wen = 1; b_req_addr = 32'h80000040; b_req_wdata = 32'h12345678;
    @(negedge clk);
    b_req_valid = 0;
    chk("b_wait_valid", {31'b0, b_rsp_valid}, 0);
    chk("b_wait_ready", {31'b0, b_req_ready}, 0);
    b_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_rst_valid", {31'b0, b_rsp_valid}, 0);
      chk("b_rst_ready", {31'b0, b_req_ready}, 0);
    end
    b_rst = 1;
    @(negedge clk);
    chk("b_rel_ready", {31'b0, b_req_ready}, 1);
    chk("b_rel_valid", {31'b0, b_rsp_valid}, 0);
    b_req_valid = 1; b_req_wen = 0;
    @(negedge clk);
    b_req_valid = 0;
    chk("b_kept_valid", {31'b0, b_rsp_valid}, 1);
    chk("b_kept_rdata", b_rsp_rdata, 32'h12345678);
    chk("b_kept_err", {31'b0, b_rsp_err}, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
